// File: rtl/exit_ctrl_pkg.sv
// Shared definitions for the simulation-exit controller: data width,
// register offsets, the timeout exit code and the controller state encoding.
package C;

    localparam int XLEN = 32;

    // Exit code reported when the watchdog ends the run
    localparam logic [XLEN-1:0] EXIT_CODE_TIMEOUT = 32'hDEAD;

    // Byte offsets of the two registers from the window base
    localparam logic [XLEN-1:0] TOHOST_OFF = 32'h0;
    localparam logic [XLEN-1:0] STATUS_OFF = 32'h8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/exit_ctrl_watchdog.sv
// Watchdog for the exit controller: counts cycles since reset release and
// flags expiry once WDOG_CYCLES cycles have elapsed. Only present when
// EXIT_WATCHDOG_EN is defined.
`ifdef EXIT_WATCHDOG_EN
module exit_watchdog #(
    parameter int WDOG_CYCLES = 100000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    output logic expired_o
);

    // Counter value seen in the last cycle before the timeout takes effect
    localparam logic [31:0] LIMIT = 32'(WDOG_CYCLES - 1);

    logic [31:0] cnt;

    // Count enabled cycles, saturating at the limit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (en_i && (cnt != LIMIT)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign expired_o = en_i && (cnt == LIMIT);

endmodule
`endif

// File: rtl/exit_ctrl.sv
// Simulation-exit controller. Two-register window: TOHOST (write with bit0=1
// to request exit, code = wdata>>1) and STATUS (bit0 draining, bit1 done).
// After a request the controller drains for DRAIN_CYCLES cycles, then raises
// a sticky exit_o with the latched code.
// Optional feature: define EXIT_WATCHDOG_EN to add a watchdog that forces
// exit with code EXIT_CODE_TIMEOUT after WDOG_CYCLES idle cycles.
module exit_ctrl
    import C::*;
#(
    parameter logic [C::XLEN-1:0] BASE_ADDR    = 'h0,
    parameter int                 DRAIN_CYCLES = 8,
    parameter int                 WDOG_CYCLES  = 100000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [C::XLEN-1:0]   req_addr_i,
    input  logic [C::XLEN-1:0]   req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [C::XLEN-1:0]   rsp_rdata_o,
    output logic                 exit_o,
    output logic [C::XLEN-1:0]   exit_code_o
);

    localparam logic [XLEN-1:0] TOHOST_ADDR = BASE_ADDR + TOHOST_OFF;
    localparam logic [XLEN-1:0] STATUS_ADDR = BASE_ADDR + STATUS_OFF;
    localparam logic [7:0]      DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);

    state_t            state;
    logic [7:0]        drain_cnt;
    logic [XLEN-1:0]   code_q;
    logic              accept;
    logic              is_tohost;
    logic              is_status;
    logic              trigger;
    logic [XLEN-1:0]   status_word;
    logic [XLEN-1:0]   rdata_next;
    logic              wd_expired;

    assign accept      = req_valid_i && req_ready_o;
    assign is_tohost   = (req_addr_i == TOHOST_ADDR);
    assign is_status   = (req_addr_i == STATUS_ADDR);
    // Only odd TOHOST values request an exit; even values are reserved
    assign trigger     = accept && req_we_i && is_tohost && req_wdata_i[0];
    assign status_word = {{(XLEN-2){1'b0}}, state == ST_DONE, state == ST_DRAIN};
    // TOHOST and out-of-range reads return zero, as do all writes
    assign rdata_next  = (!req_we_i && is_status) ? status_word : '0;

`ifdef EXIT_WATCHDOG_EN
    exit_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .en_i      (state != ST_DONE),
        .expired_o (wd_expired)
    );
`else
    // No watchdog in this build: expiry can never occur
    assign wd_expired = 1'b0 & (WDOG_CYCLES != 0);
`endif

    // Control FSM with registered handshake, response and exit outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            code_q      <= '0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            exit_o      <= 1'b0;
            exit_code_o <= '0;
        end else begin
            // Every accepted request is answered in the following cycle
            rsp_valid_o <= accept;
            rsp_rdata_o <= accept ? rdata_next : '0;

            case (state)
                ST_IDLE: begin
                    if (wd_expired) begin
                        // Watchdog wins over a simultaneous exit request
                        state       <= ST_DONE;
                        code_q      <= EXIT_CODE_TIMEOUT;
                        exit_o      <= 1'b1;
                        exit_code_o <= EXIT_CODE_TIMEOUT;
                        req_ready_o <= 1'b1;
                    end else if (trigger) begin
                        state       <= ST_DRAIN;
                        code_q      <= {1'b0, req_wdata_i[XLEN-1:1]};
                        drain_cnt   <= '0;
                        req_ready_o <= 1'b0;
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state       <= ST_DONE;
                        exit_o      <= 1'b1;
                        exit_code_o <= code_q;
                        req_ready_o <= 1'b1;
                    end else begin
                        drain_cnt   <= drain_cnt + 8'd1;
                        req_ready_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // Terminal: further TOHOST writes are answered but ignored
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exit_ctrl.sv
// Directed testbench for exit_ctrl (default build, or watchdog build when
// EXIT_WATCHDOG_EN is defined).
module tb_exit_ctrl;
    import C::*;

    localparam logic [XLEN-1:0] BASE   = 32'h100;
    localparam logic [XLEN-1:0] TOHOST = 32'h100;
    localparam logic [XLEN-1:0] STATUS = 32'h108;
    localparam logic [XLEN-1:0] OOR    = 32'h110;
`ifdef EXIT_WATCHDOG_EN
    localparam int WD = 50;
`else
    localparam int WD = 100000;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [XLEN-1:0]   req_addr_i = '0;
    logic [XLEN-1:0]   req_wdata_i = '0;
    logic              rsp_valid_o;
    logic [XLEN-1:0]   rsp_rdata_o;
    logic              exit_o;
    logic [XLEN-1:0]   exit_code_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    exit_ctrl #(
        .BASE_ADDR    (BASE),
        .DRAIN_CYCLES (8),
        .WDOG_CYCLES  (WD)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .exit_o      (exit_o),
        .exit_code_o (exit_code_o)
    );

    // Reset for two cycles, releasing on a falling edge
    task automatic apply_reset();
        req_valid_i = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Drive one request; returns at the falling edge after acceptance with
    // the response sampled there
    task automatic issue(input logic we, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] wdata, output logic acc,
                         output logic rv, output logic [XLEN-1:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = req_ready_o;
        if (!acc) begin
            req_valid_i = 1'b0;
            rv = 1'b0;
            rd = '0;
            return;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        rv = rsp_valid_o;
        rd = rsp_rdata_o;
    endtask

    task automatic test_reset();
        req_valid_i = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (req_ready_o !== 1'b0) $display("FAIL reset_ready got=%b want=0", req_ready_o);
        else pass_cnt++;
        total_cnt++;
        if ({rsp_valid_o, rsp_rdata_o} !== '0) $display("FAIL reset_rsp got=%b/%h want=0/0", rsp_valid_o, rsp_rdata_o);
        else pass_cnt++;
        total_cnt++;
        if ({exit_o, exit_code_o} !== '0) $display("FAIL reset_exit got=%b/%h want=0/0", exit_o, exit_code_o);
        else pass_cnt++;
        rstn = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready_o !== 1'b1) $display("FAIL ready_after_reset got=%b want=1", req_ready_o);
        else pass_cnt++;
    endtask

    task automatic test_reserved_write();
        logic acc, rv;
        logic [XLEN-1:0] rd;
        apply_reset();
        issue(1'b1, TOHOST, 32'h54, acc, rv, rd);
        total_cnt++;
        if ({acc, rv, rd} !== {2'b11, 32'h0}) $display("FAIL even_write_rsp got=%b%b/%h want=11/0", acc, rv, rd);
        else pass_cnt++;
        repeat (10) @(negedge clk);
        total_cnt++;
        if ({exit_o, exit_code_o, req_ready_o} !== {1'b0, 32'h0, 1'b1})
            $display("FAIL even_write_noexit got=%b/%h/%b want=0/0/1", exit_o, exit_code_o, req_ready_o);
        else pass_cnt++;
        issue(1'b0, STATUS, 32'h0, acc, rv, rd);
        total_cnt++;
        if ({acc, rv, rd} !== {2'b11, 32'h0}) $display("FAIL even_write_status got=%b%b/%h want=11/0", acc, rv, rd);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic acc, rv;
        logic [XLEN-1:0] rd;
        issue(1'b0, OOR, 32'h0, acc, rv, rd);
        total_cnt++;
        if ({acc, rv, rd} !== {2'b11, 32'h0}) $display("FAIL oor_read got=%b%b/%h want=11/0", acc, rv, rd);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("FAIL rsp_single_pulse got=%b want=0", rsp_valid_o);
        else pass_cnt++;
        issue(1'b1, OOR, 32'h55, acc, rv, rd);
        total_cnt++;
        if ({acc, rv, rd} !== {2'b11, 32'h0}) $display("FAIL oor_write got=%b%b/%h want=11/0", acc, rv, rd);
        else pass_cnt++;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (exit_o !== 1'b0) $display("FAIL oor_write_noexit got=%b want=0", exit_o);
        else pass_cnt++;
        issue(1'b0, STATUS, 32'h0, acc, rv, rd);
        total_cnt++;
        if ({rv, rd} !== {1'b1, 32'h0}) $display("FAIL oor_status got=%b/%h want=1/0", rv, rd);
        else pass_cnt++;
        issue(1'b0, TOHOST, 32'h0, acc, rv, rd);
        total_cnt++;
        if ({rv, rd} !== {1'b1, 32'h0}) $display("FAIL tohost_read got=%b/%h want=1/0", rv, rd);
        else pass_cnt++;
    endtask

    task automatic test_exit();
        logic acc, rv;
        logic [XLEN-1:0] rd;
        issue(1'b1, TOHOST, 32'h55, acc, rv, rd);
        total_cnt++;
        if ({acc, rv, rd} !== {2'b11, 32'h0}) $display("FAIL exit_write_rsp got=%b%b/%h want=11/0", acc, rv, rd);
        else pass_cnt++;
        total_cnt++;
        if ({exit_o, exit_code_o, req_ready_o} !== {1'b0, 32'h0, 1'b0})
            $display("FAIL drain_0 got=%b/%h/%b want=0/0/0", exit_o, exit_code_o, req_ready_o);
        else pass_cnt++;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            // Present a STATUS read part-way through the drain; it must stall
            if (i == 3) begin
                req_valid_i = 1'b1;
                req_we_i    = 1'b0;
                req_addr_i  = STATUS;
            end
            if (i == 5) req_valid_i = 1'b0;
            total_cnt++;
            if ({exit_o, exit_code_o, req_ready_o, rsp_valid_o} !== {1'b0, 32'h0, 1'b0, 1'b0})
                $display("FAIL drain_%0d got=%b/%h/%b/%b want=0/0/0/0", i, exit_o, exit_code_o, req_ready_o, rsp_valid_o);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({exit_o, exit_code_o, req_ready_o} !== {1'b1, 32'h2A, 1'b1})
            $display("FAIL exit_asserted got=%b/%h/%b want=1/2a/1", exit_o, exit_code_o, req_ready_o);
        else pass_cnt++;
        issue(1'b0, STATUS, 32'h0, acc, rv, rd);
        total_cnt++;
        if ({rv, rd} !== {1'b1, 32'h2}) $display("FAIL status_done got=%b/%h want=1/2", rv, rd);
        else pass_cnt++;
        issue(1'b1, TOHOST, 32'h3, acc, rv, rd);
        total_cnt++;
        if ({acc, rv} !== 2'b11) $display("FAIL done_write_rsp got=%b%b want=11", acc, rv);
        else pass_cnt++;
        repeat (12) @(negedge clk);
        total_cnt++;
        if ({exit_o, exit_code_o} !== {1'b1, 32'h2A}) $display("FAIL sticky_code got=%b/%h want=1/2a", exit_o, exit_code_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        logic acc, rv;
        logic [XLEN-1:0] rd;
        apply_reset();
        issue(1'b1, TOHOST, 32'h0B, acc, rv, rd);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        total_cnt++;
        if ({exit_o, exit_code_o, req_ready_o, rsp_valid_o} !== {1'b0, 32'h0, 1'b0, 1'b0})
            $display("FAIL mid_drain_reset got=%b/%h/%b/%b want=0/0/0/0", exit_o, exit_code_o, req_ready_o, rsp_valid_o);
        else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        total_cnt++;
        if ({exit_o, req_ready_o} !== 2'b01) $display("FAIL abandoned_exit got=%b/%b want=0/1", exit_o, req_ready_o);
        else pass_cnt++;
        issue(1'b0, STATUS, 32'h0, acc, rv, rd);
        total_cnt++;
        if ({rv, rd} !== {1'b1, 32'h0}) $display("FAIL status_after_reset got=%b/%h want=1/0", rv, rd);
        else pass_cnt++;
        issue(1'b1, TOHOST, 32'h55, acc, rv, rd);
        repeat (7) @(negedge clk);
        total_cnt++;
        if (exit_o !== 1'b0) $display("FAIL reexit_early got=%b want=0", exit_o);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({exit_o, exit_code_o} !== {1'b1, 32'h2A}) $display("FAIL reexit got=%b/%h want=1/2a", exit_o, exit_code_o);
        else pass_cnt++;
    endtask

    task automatic test_watchdog();
        logic acc, rv;
        logic [XLEN-1:0] rd;
        int early;
        early = 0;
        apply_reset();
        for (int k = 1; k < 50; k++) begin
            @(negedge clk);
            if (exit_o !== 1'b0) early++;
        end
        total_cnt++;
        if (early != 0) $display("FAIL wdog_early got=%0d early cycles want=0", early);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({exit_o, exit_code_o} !== {1'b1, 32'hDEAD}) $display("FAIL wdog_expiry got=%b/%h want=1/dead", exit_o, exit_code_o);
        else pass_cnt++;
        issue(1'b1, TOHOST, 32'h55, acc, rv, rd);
        repeat (10) @(negedge clk);
        total_cnt++;
        if ({rv, exit_code_o} !== {1'b1, 32'hDEAD}) $display("FAIL wdog_sticky got=%b/%h want=1/dead", rv, exit_code_o);
        else pass_cnt++;
        issue(1'b0, STATUS, 32'h0, acc, rv, rd);
        total_cnt++;
        if ({rv, rd} !== {1'b1, 32'h2}) $display("FAIL wdog_status got=%b/%h want=1/2", rv, rd);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
`ifdef EXIT_WATCHDOG_EN
        test_watchdog();
`else
        test_reserved_write();
        test_out_of_range();
        test_exit();
        test_reset_mid_drain();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
